burst_write_master: RTL
=======================

// Module: burst_write_master
// PURPOSE
//  CSR-programmed Avalon-MM write master with burst support.
//  - User logic streams words into an internal FIFO.
//  - The block drains the FIFO to memory as bursts of up to MAXBURSTCOUNT beats,
//    until the programmed byte length is transferred; it then flags done and
//    optionally raises irq.
//  - Sits between a Nios/host CSR bus and an SDRAM/on-chip memory slave.
//    Adds burst, abort and interrupt over the single-beat write master.
// PARAMETERS
//  DATAWIDTH        32  master data width, bits (multiple of 8)
//  BYTEENABLEWIDTH  4   DATAWIDTH/8
//  ADDRESSWIDTH     32  master address width
//  MAXBURSTCOUNT    8   max beats per burst, power of 2, >=1
//  BURSTCOUNTWIDTH  4   log2(MAXBURSTCOUNT)+1
//  FIFODEPTH        32  FIFO words, power of 2, >= MAXBURSTCOUNT
//  FIFODEPTH_LOG2   5   log2(FIFODEPTH)
// PORTS
//  clk                 in   1      system clock
//  reset_n             in   1      async active-low reset
//  avs_csr_address     in   3      CSR word address
//  avs_csr_write       in   1      CSR write strobe
//  avs_csr_writedata   in   32     CSR write data
//  avs_csr_readdata    out  32     CSR read data, combinational from address
//  irq                 out  1      level interrupt: done & irq_en
//  user_write_buffer   in   1      push user_buffer_data into FIFO
//  user_buffer_data    in   DATAWIDTH  FIFO write data
//  user_buffer_full    out  1      FIFO full; pushes while full are dropped
//  master_address      out  ADDRESSWIDTH  byte address, held for whole burst
//  master_write        out  1      write request
//  master_byteenable   out  BYTEENABLEWIDTH  all ones
//  master_burstcount   out  BURSTCOUNTWIDTH  beats in current burst
//  master_writedata    out  DATAWIDTH  FIFO head word
//  master_waitrequest  in   1      slave stall
// BEHAVIOUR
//  CSR map (32-bit registers):
//   0 CONTROL: W bit0 go (1-cycle pulse), bit1 fixed_location, bit2 abort (pulse).
//              R/W bit3 irq_en.
//   1 STATUS: R {aborted[4], fifo_full[3], fifo_empty[2], busy[1], done[0]}.
//             Write any value clears done and aborted.
//   2 BASE: R/W, bits[log2(BYTEENABLEWIDTH)-1:0] forced to 0.
//   3 LENGTH: R/W bytes, low bits forced to 0. Readback = programmed value.
//   4 REMAIN: R bytes still to write. Other addresses read 0.
//  Reset: all registers, FIFO pointers, outputs 0. The FIFO reads empty (status bit2=1).
//  FSM states IDLE, WAIT_DATA, BURST, DRAIN:
//   - IDLE, go: address<=BASE, remain<=LENGTH, fixed latched, done<=0.
//       - LENGTH==0: done<=1 next cycle, stay IDLE.
//       - Otherwise -> WAIT_DATA.
//   - go while not IDLE is ignored.
//   - WAIT_DATA: beats = min(MAXBURSTCOUNT, remain/BYTEENABLEWIDTH), or 1 if fixed.
//       - Enter BURST once fifo_level >= beats.
//       - Burst never starts on a partial FIFO.
//   - BURST: master_write=1, burstcount=beats, address constant.
//       - Beat accepted when waitrequest=0: pop FIFO, decrement remain by BYTEENABLEWIDTH.
//       - After the last beat: address += beats*BYTEENABLEWIDTH (unless fixed).
//       - Then remain==0 -> IDLE with done<=1, else -> WAIT_DATA.
//   - abort:
//       - In WAIT_DATA: -> DRAIN immediately.
//       - In BURST: the current burst completes (Avalon rule), then -> DRAIN.
//       - DRAIN flushes the FIFO in one cycle, sets aborted=1 and done=1, -> IDLE.
//  busy = (state != IDLE).
//  FIFO: showahead. Push and pop in the same cycle keep the level unchanged, even when full.
//  Pointers wrap modulo FIFODEPTH. Level is FIFODEPTH_LOG2+1 bits.
//  Address arithmetic wraps modulo 2^ADDRESSWIDTH.
//  CSR write and FSM update of the same bit in one cycle: the FSM set of done wins over the CSR clear.
// TESTING
//  - LENGTH=64, MAXBURST=8, push 16 words, no waitrequest -> 2 bursts of 8 at BASE and BASE+32; done, irq if irq_en.
//  - LENGTH=20 -> bursts of 5, address BASE; then done. Data order matches push order.
//  - fixed_location=1, LENGTH=16 -> 4 single-beat writes, all to BASE.
//  - Push 3 words, LENGTH=32 -> master_write stays 0 until level>=8.
//  - Random waitrequest -> address/burstcount/data held while stalled.
//  - Abort mid-burst -> burst finishes. Then FIFO empty, STATUS=0x15 (aborted, empty, done).
//  - reset_n low mid-burst -> master_write=0 at once; STATUS=0x04 after release.
//  - LENGTH=0 go -> done=1 next cycle, no master_write.

Source files
------------

// File: rtl/burst_write_master.sv
// Avalon-MM burst write master programmed over a small CSR bank.
// User logic fills a showahead FIFO; the FSM drains it to memory in bursts
// of up to MAXBURSTCOUNT beats until LENGTH bytes are written, then flags done.
// Handshake: a beat transfers on a rising clk edge where master_write=1 and
// master_waitrequest=0; address, burstcount and data hold while stalled.
module burst_write_master #(
    parameter int DATAWIDTH       = 32,
    parameter int BYTEENABLEWIDTH = 4,
    parameter int ADDRESSWIDTH    = 32,
    parameter int MAXBURSTCOUNT   = 8,
    parameter int BURSTCOUNTWIDTH = 4,
    parameter int FIFODEPTH       = 32,
    parameter int FIFODEPTH_LOG2  = 5
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [2:0]                 avs_csr_address,
    input  logic                       avs_csr_write,
    input  logic [31:0]                avs_csr_writedata,
    output logic [31:0]                avs_csr_readdata,
    output logic                       irq,
    input  logic                       user_write_buffer,
    input  logic [DATAWIDTH-1:0]       user_buffer_data,
    output logic                       user_buffer_full,
    output logic [ADDRESSWIDTH-1:0]    master_address,
    output logic                       master_write,
    output logic [BYTEENABLEWIDTH-1:0] master_byteenable,
    output logic [BURSTCOUNTWIDTH-1:0] master_burstcount,
    output logic [DATAWIDTH-1:0]       master_writedata,
    input  logic                       master_waitrequest,
    output logic [1:0]                 state_dbg
);

    localparam int BE_LOG2 = $clog2(BYTEENABLEWIDTH);
    localparam logic [31:0] LOW_MASK = 32'(BYTEENABLEWIDTH - 1);
    localparam logic [31:0] BEAT_BYTES = 32'(BYTEENABLEWIDTH);

    typedef enum logic [1:0] {IDLE, WAIT_DATA, BURST, DRAIN} state_t;

    state_t                     state;
    logic [ADDRESSWIDTH-1:0]    base_reg;
    logic [31:0]                length_reg;
    logic [31:0]                remain;
    logic                       irq_en;
    logic                       fixed;
    logic                       done;
    logic                       aborted;
    logic                       abort_pend;
    logic [BURSTCOUNTWIDTH-1:0] beat_cnt;
    logic [BURSTCOUNTWIDTH-1:0] beats_next;
    logic [31:0]                words_left;

    logic [DATAWIDTH-1:0]       fifo_mem [FIFODEPTH];
    logic [FIFODEPTH_LOG2-1:0]  wr_ptr;
    logic [FIFODEPTH_LOG2-1:0]  rd_ptr;
    logic [FIFODEPTH_LOG2:0]    fifo_level;
    logic                       fifo_full;
    logic                       fifo_empty;
    logic                       push;
    logic                       pop;
    logic                       flush;

    logic csr_ctrl_wr;
    logic csr_status_wr;
    logic go;
    logic abort_req;

    assign csr_ctrl_wr   = avs_csr_write && (avs_csr_address == 3'd0);
    assign csr_status_wr = avs_csr_write && (avs_csr_address == 3'd1);
    assign go            = csr_ctrl_wr && avs_csr_writedata[0];
    assign abort_req     = csr_ctrl_wr && avs_csr_writedata[2];

    // A full FIFO still accepts a push when a pop frees a slot in the same cycle.
    assign fifo_full  = (fifo_level == (FIFODEPTH_LOG2 + 1)'(FIFODEPTH));
    assign fifo_empty = (fifo_level == '0);
    assign pop        = master_write && !master_waitrequest;
    assign push       = user_write_buffer && (!fifo_full || pop);
    assign flush      = (state == DRAIN);

    assign user_buffer_full  = fifo_full;
    assign master_byteenable = master_write ? '1 : '0;
    assign master_writedata  = master_write ? fifo_mem[rd_ptr] : '0;
    assign irq               = done && irq_en;
    assign state_dbg         = state;

    // Burst size for the next burst: capped by MAXBURSTCOUNT and remaining words.
    always_comb begin
        words_left = remain >> BE_LOG2;
        beats_next = '0;
        if (fixed)
            beats_next = BURSTCOUNTWIDTH'(1);
        else if (words_left >= 32'(MAXBURSTCOUNT))
            beats_next = BURSTCOUNTWIDTH'(MAXBURSTCOUNT);
        else
            beats_next = words_left[BURSTCOUNTWIDTH-1:0];
    end

    // FIFO storage; contents need no reset because the pointers gate visibility.
    always_ff @(posedge clk) begin
        if (push && !flush)
            fifo_mem[wr_ptr] <= user_buffer_data;
    end

    // FIFO pointers and level; DRAIN empties it in one cycle and drops that cycle's push.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else if (flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                fifo_level <= fifo_level + 1'b1;
            else if (pop && !push)
                fifo_level <= fifo_level - 1'b1;
        end
    end

    // CSR-owned configuration registers; byte offsets within a word are forced to 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            base_reg   <= '0;
            length_reg <= '0;
            irq_en     <= 1'b0;
        end else if (avs_csr_write) begin
            case (avs_csr_address)
                3'd0: irq_en     <= avs_csr_writedata[3];
                3'd2: base_reg   <= ADDRESSWIDTH'(avs_csr_writedata & ~LOW_MASK);
                3'd3: length_reg <= avs_csr_writedata & ~LOW_MASK;
                default: ;
            endcase
        end
    end

    // Transfer FSM; the status clear comes first so any FSM set of done/aborted wins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state             <= IDLE;
            master_address    <= '0;
            master_write      <= 1'b0;
            master_burstcount <= '0;
            remain            <= '0;
            fixed             <= 1'b0;
            done              <= 1'b0;
            aborted           <= 1'b0;
            abort_pend        <= 1'b0;
            beat_cnt          <= '0;
        end else begin
            if (csr_status_wr) begin
                done    <= 1'b0;
                aborted <= 1'b0;
            end
            case (state)
                IDLE: begin
                    abort_pend <= 1'b0;
                    if (go) begin
                        master_address <= base_reg;
                        remain         <= length_reg;
                        fixed          <= avs_csr_writedata[1];
                        done           <= (length_reg == '0);
                        state          <= (length_reg == '0) ? IDLE : WAIT_DATA;
                    end
                end
                WAIT_DATA: begin
                    if (abort_req || abort_pend) begin
                        state <= DRAIN;
                    end else if (fifo_level >= (FIFODEPTH_LOG2 + 1)'(beats_next)) begin
                        state             <= BURST;
                        master_write      <= 1'b1;
                        master_burstcount <= beats_next;
                        beat_cnt          <= beats_next;
                    end
                end
                BURST: begin
                    if (abort_req)
                        abort_pend <= 1'b1;
                    if (pop) begin
                        remain   <= remain - BEAT_BYTES;
                        beat_cnt <= beat_cnt - 1'b1;
                        if (beat_cnt == BURSTCOUNTWIDTH'(1)) begin
                            master_write      <= 1'b0;
                            master_burstcount <= '0;
                            if (!fixed)
                                master_address <= master_address +
                                    (ADDRESSWIDTH'(master_burstcount) << BE_LOG2);
                            if (abort_pend || abort_req) begin
                                state <= DRAIN;
                            end else if (remain == BEAT_BYTES) begin
                                state <= IDLE;
                                done  <= 1'b1;
                            end else begin
                                state <= WAIT_DATA;
                            end
                        end
                    end
                end
                DRAIN: begin
                    aborted    <= 1'b1;
                    done       <= 1'b1;
                    abort_pend <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // CSR readback, combinational from the address.
    always_comb begin
        avs_csr_readdata = '0;
        case (avs_csr_address)
            3'd0: avs_csr_readdata = {28'b0, irq_en, 3'b0};
            3'd1: avs_csr_readdata = {27'b0, aborted, fifo_full, fifo_empty,
                                      (state != IDLE), done};
            3'd2: avs_csr_readdata = 32'(base_reg);
            3'd3: avs_csr_readdata = length_reg;
            3'd4: avs_csr_readdata = remain;
            default: avs_csr_readdata = '0;
        endcase
    end

endmodule
